zoom_engine: RTL and testbench

Nearest-neighbour zoom engine that fills the 320x240, 8-bit-per-pixel display frame buffer from a 320x240 source image memory. On a start pulse it walks every destination pixel in raster order, computes the source address for the selected mode, reads the source and writes the result into the frame-buffer write port. It sits directly upstream of the VGA display controller, which only reads the frame buffer. One full pass rewrites all 76800 destination pixels.

---
 rtl/zoom_engine.sv | 199 +++++++++++++++++++
 tb/tb_zoom_engine.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/zoom_engine.sv
// Nearest-neighbour zoom engine: copy, 2x zoom-in or /2 zoom-out from a source image into the frame buffer.
// Optional feature macro: ZOOM_BORDER_EN (white 1-pixel outline around the zoom-out image).

module zoom_engine #(
  parameter int SRC_W  = 320,
  parameter int SRC_H  = 240,
  parameter int ADDR_W = 17,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [8:0]        off_x,
  input  logic [7:0]        off_y,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] src_addr,
  output logic              src_rden,
  input  logic [7:0]        src_q,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [7:0]        dst_data,
  output logic              dst_wren
);

  localparam int XW = $clog2(SRC_W);
  localparam int YW = $clog2(SRC_H);
  localparam int XQ = SRC_W / 4;
  localparam int YQ = SRC_H / 4;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              r_state;
  logic [1:0]          r_mode;
  logic [8:0]          r_ox;
  logic [7:0]          r_oy;
  logic [XW-1:0]       r_dx;
  logic [YW-1:0]       r_dy;
  logic [ADDR_W-1:0]   r_lin;
  logic [RD_LAT:0]     r_pVld;
  logic [RD_LAT:0]     r_pFill;
  logic [RD_LAT:0]     r_pBord;
  logic [ADDR_W-1:0]   r_pDst [RD_LAT+1];

  logic                w_idle;
  logic                w_issue;
  logic                w_lastCol;
  logic                w_nextLast;
  logic [8:0]          w_clampX;
  logic [7:0]          w_clampY;
  logic [1:0]          w_mode;
  logic [8:0]          w_ox;
  logic [7:0]          w_oy;
  logic [XW-1:0]       w_px;
  logic [YW-1:0]       w_py;
  logic [ADDR_W-1:0]   w_lin;
  logic [ADDR_W-1:0]   w_x;
  logic [ADDR_W-1:0]   w_y;
  logic [ADDR_W-1:0]   w_sx;
  logic [ADDR_W-1:0]   w_sy;
  logic [ADDR_W-1:0]   w_srcAddr;
  logic                w_inWin;
  logic                w_fill;
  logic                w_border;

  assign w_clampX  = (off_x > 9'(SRC_W / 2)) ? 9'(SRC_W / 2) : off_x;
  assign w_clampY  = (off_y > 8'(SRC_H / 2)) ? 8'(SRC_H / 2) : off_y;
  assign w_idle    = (r_state == IDLE);
  assign w_issue   = (w_idle && start) || (r_state == RUN);
  assign w_lastCol = (r_dx == XW'(SRC_W - 1));

  // On acceptance the first pixel is issued from the live inputs, since the latches fill on the same edge.
  assign w_mode = w_idle ? mode     : r_mode;
  assign w_ox   = w_idle ? w_clampX : r_ox;
  assign w_oy   = w_idle ? w_clampY : r_oy;

  always_comb begin
    w_px  = '0;
    w_py  = '0;
    w_lin = '0;
    if (!w_idle) begin
      w_px  = w_lastCol ? '0 : r_dx + 1'b1;
      w_py  = w_lastCol ? r_dy + 1'b1 : r_dy;
      w_lin = r_lin + 1'b1;
    end
  end

  assign w_nextLast = (w_px == XW'(SRC_W - 1)) && (w_py == YW'(SRC_H - 1));
  assign w_x        = ADDR_W'(w_px);
  assign w_y        = ADDR_W'(w_py);
  assign w_inWin    = (w_x >= ADDR_W'(XQ)) && (w_x < ADDR_W'(3 * XQ)) &&
                      (w_y >= ADDR_W'(YQ)) && (w_y < ADDR_W'(3 * YQ));

`ifdef ZOOM_BORDER_EN
  logic w_inRing;
  assign w_inRing = (w_x >= ADDR_W'(XQ - 1)) && (w_x <= ADDR_W'(3 * XQ)) &&
                    (w_y >= ADDR_W'(YQ - 1)) && (w_y <= ADDR_W'(3 * YQ));
`endif

  always_comb begin
    w_sx     = w_x;
    w_sy     = w_y;
    w_fill   = 1'b0;
    w_border = 1'b0;
    case (w_mode)
      2'b01: begin
        w_sx = ADDR_W'(w_ox) + (w_x >> 1);
        w_sy = ADDR_W'(w_oy) + (w_y >> 1);
      end
      2'b10: begin
        if (w_inWin) begin
          w_sx = (w_x - ADDR_W'(XQ)) << 1;
          w_sy = (w_y - ADDR_W'(YQ)) << 1;
        end else begin
          w_sx   = '0;
          w_sy   = '0;
          w_fill = 1'b1;
`ifdef ZOOM_BORDER_EN
          w_border = w_inRing;
`endif
        end
      end
      default: ;
    endcase
    w_srcAddr = w_sy * ADDR_W'(SRC_W) + w_sx;
  end

  // Control FSM, issue stage, read-latency pipeline and write port in one registered block.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_mode   <= 2'b00;
      r_ox     <= '0;
      r_oy     <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_lin    <= '0;
      r_pVld   <= '0;
      r_pFill  <= '0;
      r_pBord  <= '0;
      for (int k = 0; k <= RD_LAT; k++) r_pDst[k] <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      src_addr <= '0;
      src_rden <= 1'b0;
      dst_addr <= '0;
      dst_data <= 8'h00;
      dst_wren <= 1'b0;
    end else begin
      r_pVld    <= {r_pVld[RD_LAT-1:0], w_issue};
      r_pFill   <= {r_pFill[RD_LAT-1:0], w_fill};
      r_pBord   <= {r_pBord[RD_LAT-1:0], w_border};
      r_pDst[0] <= w_lin;
      for (int k = 1; k <= RD_LAT; k++) r_pDst[k] <= r_pDst[k-1];

      src_rden <= w_issue && !w_fill;
      if (w_issue) begin
        src_addr <= w_srcAddr;
        r_dx     <= w_px;
        r_dy     <= w_py;
        r_lin    <= w_lin;
      end

      dst_wren <= r_pVld[RD_LAT];
      if (r_pVld[RD_LAT]) begin
        dst_addr <= r_pDst[RD_LAT];
        dst_data <= r_pFill[RD_LAT] ? (r_pBord[RD_LAT] ? 8'hFF : 8'h00) : src_q;
      end

      case (r_state)
        IDLE: begin
          if (start) begin
            r_mode  <= mode;
            r_ox    <= w_clampX;
            r_oy    <= w_clampY;
            busy    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_nextLast) r_state <= DRAIN;
        end
        DRAIN: begin
          if (r_pVld == '0) begin
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zoom_engine.sv
// Self-checking bench for zoom_engine on a 64x48 image, with a source-memory model and a pixel reference model.
// Honours ZOOM_BORDER_EN in the expected zoom-out fill values.

module tb_zoom_engine;

  localparam int W    = 64;
  localparam int H    = 48;
  localparam int NPIX = W * H;
  localparam int RDL  = 1;
  localparam int AW   = 17;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode  = 2'b00;
  logic [8:0]    off_x = '0;
  logic [7:0]    off_y = '0;
  logic          busy, done, src_rden, dst_wren;
  logic [AW-1:0] src_addr, dst_addr;
  logic [7:0]    src_q, dst_data;

  logic [7:0] srcMem [NPIX];
  logic [7:0] fb     [NPIX];
  logic [7:0] rdPipe [RDL];

  int cyc = 0;
  int compareCount = 0;
  int mismatchCount = 0;
  int passWrites, passErrs, passRden, passBusy, doneCnt, firstWrCyc, doneCyc;
  int refMode, refOx, refOy;
  int e0;

  zoom_engine #(.SRC_W(W), .SRC_H(H), .ADDR_W(AW), .RD_LAT(RDL)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode),
    .off_x(off_x), .off_y(off_y), .busy(busy), .done(done),
    .src_addr(src_addr), .src_rden(src_rden), .src_q(src_q),
    .dst_addr(dst_addr), .dst_data(dst_data), .dst_wren(dst_wren)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] readSrc(input int a);
    if (a >= 0 && a < NPIX) return srcMem[a];
    return 8'hEE;
  endfunction

  // Source memory: data appears RDL cycles after the address edge, and only for enabled reads.
  always @(posedge clock) begin
    if (src_rden) rdPipe[0] <= readSrc(int'(src_addr));
    for (int k = 1; k < RDL; k++) rdPipe[k] <= rdPipe[k-1];
  end
  assign src_q = rdPipe[RDL-1];

  // Expected destination pixel for raster index idx under the latched mode/offsets.
  function automatic int refPixel(input int idx);
    int dx, dy;
    dx = idx % W;
    dy = idx / W;
    case (refMode)
      1: return int'(readSrc((refOy + dy / 2) * W + refOx + dx / 2));
      2: begin
        if (dx >= W/4 && dx < 3*W/4 && dy >= H/4 && dy < 3*H/4)
          return int'(readSrc(2 * (dy - H/4) * W + 2 * (dx - W/4)));
`ifdef ZOOM_BORDER_EN
        if (dx >= W/4 - 1 && dx <= 3*W/4 && dy >= H/4 - 1 && dy <= 3*H/4) return 255;
`endif
        return 0;
      end
      default: return int'(readSrc(idx));
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compareCount++;
    if (got !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Write-port and activity monitor, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (dst_wren) begin
          if (passWrites == 0) firstWrCyc = cyc;
          if (int'(dst_addr) < NPIX) fb[int'(dst_addr)] = dst_data;
          if (int'(dst_addr) != passWrites || int'(dst_data) != refPixel(passWrites)) passErrs++;
          passWrites++;
        end
        if (src_rden) passRden++;
        if (busy) passBusy++;
        if (done) begin
          doneCnt++;
          doneCyc = cyc;
        end
      end
    end
  end

  task automatic clearStats();
    passWrites = 0; passErrs = 0; passRden = 0; passBusy = 0;
    doneCnt = 0; firstWrCyc = -1; doneCyc = -1;
  endtask

  // Must be called at a falling edge; returns at the falling edge after done drops.
  task automatic applyStimulus(input logic [1:0] md, input int ox, input int oy,
                               input bit disturb, input string tag);
    bit timedOut;
    int expRden;
    mode  = md;
    off_x = 9'(ox);
    off_y = 8'(oy);
    start = 1'b1;
    clearStats();
    refMode = int'(md);
    refOx   = (ox > W/2) ? W/2 : ox;
    refOy   = (oy > H/2) ? H/2 : oy;
    expRden = (md == 2'b10) ? (W/2) * (H/2) : NPIX;
    @(posedge clock);
    #1;
    e0 = cyc;
    start = 1'b0;
    checkOutput({tag, "_busyE0"}, 32'(busy), 32'd1);
    checkOutput({tag, "_rdenE0"}, 32'(src_rden), (md == 2'b10) ? 32'd0 : 32'd1);
    if (md != 2'b10) checkOutput({tag, "_addrE0"}, 32'(src_addr), 32'(md == 2'b01 ? refOy * W + refOx : 0));
    timedOut = 1'b1;
    for (int n = 0; n < NPIX + 200; n++) begin
      @(negedge clock);
      if (disturb && cyc == e0 + 1000) begin
        start = 1'b1;
        mode  = 2'b01;
        off_x = 9'd3;
      end else if (disturb && cyc == e0 + 1001) begin
        start = 1'b0;
      end
      if (done) begin
        timedOut = 1'b0;
        break;
      end
    end
    @(negedge clock);
    checkOutput({tag, "_timeout"}, 32'(timedOut), 32'd0);
    checkOutput({tag, "_busyAfter"}, 32'(busy), 32'd0);
    checkOutput({tag, "_doneAfter"}, 32'(done), 32'd0);
    checkOutput({tag, "_writes"}, passWrites, NPIX);
    checkOutput({tag, "_badPixels"}, passErrs, 0);
    checkOutput({tag, "_reads"}, passRden, expRden);
    checkOutput({tag, "_firstWrLat"}, firstWrCyc - e0, RDL + 1);
    checkOutput({tag, "_doneLat"}, doneCyc - e0, NPIX - 1 + RDL + 2);
    checkOutput({tag, "_donePulses"}, doneCnt, 1);
    checkOutput({tag, "_busyCycles"}, passBusy, NPIX + RDL + 2);
  endtask

  task automatic resetMidPass();
    int wrAtReset;
    mode  = 2'b00;
    start = 1'b1;
    clearStats();
    refMode = 0; refOx = 0; refOy = 0;
    @(posedge clock);
    #1;
    e0 = cyc;
    start = 1'b0;
    while (cyc < e0 + 500) @(negedge clock);
    reset = 1'b1;
    #1;
    wrAtReset = passWrites;
    checkOutput("rst_wren", 32'(dst_wren), 32'd0);
    checkOutput("rst_rden", 32'(src_rden), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_partialWrites", 32'(wrAtReset > 400), 32'd1);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    checkOutput("rst_noMoreWrites", passWrites, wrAtReset);
    checkOutput("rst_idleBusy", 32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < RDL; i++) rdPipe[i] = 8'h00;
    for (int i = 0; i < NPIX; i++) begin
      srcMem[i] = 8'(i);
      fb[i]     = 8'h55;
    end
    clearStats();
    #2 reset = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("reset_busy",     32'(busy),     32'd0);
    checkOutput("reset_done",     32'(done),     32'd0);
    checkOutput("reset_src_rden", 32'(src_rden), 32'd0);
    checkOutput("reset_src_addr", 32'(src_addr), 32'd0);
    checkOutput("reset_dst_wren", 32'(dst_wren), 32'd0);
    checkOutput("reset_dst_addr", 32'(dst_addr), 32'd0);
    checkOutput("reset_dst_data", 32'(dst_data), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    applyStimulus(2'b00, 0, 0, 1'b0, "copy");
    checkOutput("copy_px300", 32'(fb[300]), 32'(300 % 256));

    for (int i = 0; i < NPIX; i++) srcMem[i] = 8'($urandom);

    applyStimulus(2'b01, 10, 5, 1'b0, "zin");
    checkOutput("zin_px00", 32'(fb[0]),     32'(srcMem[5*W + 10]));
    checkOutput("zin_px10", 32'(fb[1]),     32'(srcMem[5*W + 10]));
    checkOutput("zin_px01", 32'(fb[W]),     32'(srcMem[5*W + 10]));
    checkOutput("zin_px11", 32'(fb[W + 1]), 32'(srcMem[5*W + 10]));
    checkOutput("zin_last", 32'(fb[NPIX-1]), 32'(srcMem[(5 + (H-1)/2) * W + 10 + (W-1)/2]));

    applyStimulus(2'b01, 300, 200, 1'b0, "zclamp");
    checkOutput("zclamp_last", 32'(fb[NPIX-1]), 32'(srcMem[NPIX-1]));

    applyStimulus(2'b10, 0, 0, 1'b0, "zout");
    checkOutput("zout_winFirst", 32'(fb[(H/4)*W + W/4]), 32'(srcMem[0]));
    checkOutput("zout_winLast", 32'(fb[(3*H/4 - 1)*W + 3*W/4 - 1]), 32'(srcMem[(H-2)*W + W - 2]));
    checkOutput("zout_corner", 32'(fb[0]), 32'd0);
`ifdef ZOOM_BORDER_EN
    checkOutput("zout_ringCorner", 32'(fb[(H/4 - 1)*W + W/4 - 1]), 32'd255);
`else
    checkOutput("zout_ringCorner", 32'(fb[(H/4 - 1)*W + W/4 - 1]), 32'd0);
`endif

    applyStimulus(2'b11, int'($urandom_range(0, 511)), int'($urandom_range(0, 255)), 1'b0, "mode3");
    applyStimulus(2'b01, int'($urandom_range(0, 40)), int'($urandom_range(0, 30)), 1'b0, "zrand");
    applyStimulus(2'b00, 0, 0, 1'b1, "disturb");

    resetMidPass();
    applyStimulus(2'b00, 0, 0, 1'b0, "afterRst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
